// File: rtl/axi4_duth_noc_pkg.sv
// Shared helpers for the NoC serializer/deserializer family.
//   get_max2 : larger of two integers, used to size shared buffers.
package axi4_duth_noc_pkg;
  function automatic int get_max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ser_shared_gen.sv
// ser_shared_gen: splits a parallel word into SER_WIDTH flits, lowest slice
// first. Two word formats share one buffer; count_sel picks COUNT_0 or
// COUNT_1 flits per word and is latched with the accepted word.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   count_sel      : 0 -> parallel_in_0 / COUNT_0, 1 -> parallel_in_1 / COUNT_1
//   parallel_in_0  : SER_WIDTH*COUNT_0 word
//   parallel_in_1  : SER_WIDTH*COUNT_1 word
//   valid_in       : word valid
//   ready_out      : word can be accepted this cycle
//   serial_out     : current flit
//   valid_out      : flit valid
//   ready_in       : downstream takes flit this cycle
//   last_out       : final flit of the word
module ser_shared_gen
  import axi4_duth_noc_pkg::*;
#(
  parameter int SER_WIDTH = 16,
  parameter int COUNT_0   = 2,
  parameter int COUNT_1   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         count_sel,
  input  logic [SER_WIDTH*COUNT_0-1:0] parallel_in_0,
  input  logic [SER_WIDTH*COUNT_1-1:0] parallel_in_1,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [SER_WIDTH-1:0]         serial_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         last_out
);

  localparam int COUNT_MAX = get_max2(COUNT_0, COUNT_1);
  localparam int CW        = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

  logic [COUNT_MAX-1:0][SER_WIDTH-1:0] word_q;
  logic [COUNT_MAX-1:0][SER_WIDTH-1:0] load_word;
  logic [CW-1:0]                       idx;
  logic                                sel_q;
  logic                                busy;
  logic [CW-1:0]                       last_idx;
  logic                                accept;
  logic                                xfer;

  // Selected input packed into the shared buffer; unused upper slices zero.
  always_comb begin
    load_word = '0;
    if (count_sel) begin
      for (int i = 0; i < COUNT_1; i++)
        load_word[i] = parallel_in_1[i*SER_WIDTH +: SER_WIDTH];
    end else begin
      for (int i = 0; i < COUNT_0; i++)
        load_word[i] = parallel_in_0[i*SER_WIDTH +: SER_WIDTH];
    end
  end

  assign last_idx   = sel_q ? CW'(COUNT_1 - 1) : CW'(COUNT_0 - 1);
  assign valid_out  = busy;
  assign serial_out = word_q[idx];
  assign last_out   = busy & (idx == last_idx);
  // Final flit leaving frees the buffer in the same cycle: no bubble.
  assign ready_out  = ~busy | (last_out & ready_in);
  assign accept     = valid_in & ready_out;
  assign xfer       = valid_out & ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      idx   <= '0;
      sel_q <= 1'b0;
    end else if (accept) begin
      busy  <= 1'b1;
      idx   <= '0;
      sel_q <= count_sel;
    end else if (xfer) begin
      if (last_out) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Data path carries no reset; busy alone qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && accept) word_q <= load_word;
  end

endmodule

// File: tb/tb_ser_shared_gen.sv
// Directed bench for ser_shared_gen at default parameters (16-bit flits,
// 2 flits for count_sel=0, 1 flit for count_sel=1).
module tb_ser_shared_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        count_sel;
  logic [31:0] parallel_in_0;
  logic [15:0] parallel_in_1;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] serial_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;

  int checks = 0;
  int errors = 0;

  ser_shared_gen dut (
    .clk          (clk),
    .rst          (rst),
    .count_sel    (count_sel),
    .parallel_in_0(parallel_in_0),
    .parallel_in_1(parallel_in_1),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .serial_out   (serial_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .last_out     (last_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs/outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; count_sel = 1'b0; parallel_in_0 = '0; parallel_in_1 = '0;
    valid_in = 1'b0; ready_in = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_last",  32'(last_out),  32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);

    // Two-flit word, lowest slice first.
    parallel_in_0 = 32'hBEEF_1234; valid_in = 1'b1; #1;
    chk("w0_rdy_idle", 32'(ready_out), 32'd1);
    tick(); valid_in = 1'b0; #1;
    chk("w0_f0_v",    32'(valid_out),  32'd1);
    chk("w0_f0",      32'(serial_out), 32'h1234);
    chk("w0_f0_last", 32'(last_out),   32'd0);
    chk("w0_f0_rdy",  32'(ready_out),  32'd0);
    tick();
    chk("w0_f1",      32'(serial_out), 32'hBEEF);
    chk("w0_f1_last", 32'(last_out),   32'd1);
    chk("w0_f1_rdy",  32'(ready_out),  32'd1);
    tick();
    chk("w0_done",    32'(valid_out),  32'd0);

    // Single-flit words back to back.
    count_sel = 1'b1; parallel_in_1 = 16'h00AA; valid_in = 1'b1;
    tick(); parallel_in_1 = 16'h00BB; #1;
    chk("s1_a",      32'(serial_out), 32'h00AA);
    chk("s1_a_last", 32'(last_out),   32'd1);
    chk("s1_a_rdy",  32'(ready_out),  32'd1);
    tick(); valid_in = 1'b0; #1;
    chk("s1_b_v",    32'(valid_out),  32'd1);
    chk("s1_b",      32'(serial_out), 32'h00BB);
    chk("s1_b_last", 32'(last_out),   32'd1);
    tick();
    chk("s1_done",   32'(valid_out),  32'd0);

    // Two words held valid: second accept overlaps first word's last flit.
    count_sel = 1'b0; parallel_in_0 = 32'h2222_1111; valid_in = 1'b1;
    tick(); parallel_in_0 = 32'h4444_3333; #1;
    chk("bb_f0",     32'(serial_out), 32'h1111);
    chk("bb_f0_rdy", 32'(ready_out),  32'd0);
    tick();
    chk("bb_f1",     32'(serial_out), 32'h2222);
    chk("bb_f1_rdy", 32'(ready_out),  32'd1);
    tick(); valid_in = 1'b0; #1;
    chk("bb_f2_v",   32'(valid_out),  32'd1);
    chk("bb_f2",     32'(serial_out), 32'h3333);
    tick();
    chk("bb_f3",     32'(serial_out), 32'h4444);
    chk("bb_f3_last",32'(last_out),   32'd1);
    tick();
    chk("bb_done",   32'(valid_out),  32'd0);

    // Backpressure holds the first flit.
    parallel_in_0 = 32'hBEEF_1234; valid_in = 1'b1;
    tick(); valid_in = 1'b0; ready_in = 1'b0; #1;
    chk("bp_f0", 32'(serial_out), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold",      32'(serial_out), 32'h1234);
      chk("bp_hold_last", 32'(last_out),   32'd0);
      chk("bp_hold_rdy",  32'(ready_out),  32'd0);
    end
    ready_in = 1'b1; #1;
    chk("bp_rel",      32'(serial_out), 32'h1234);
    tick();
    chk("bp_f1",       32'(serial_out), 32'hBEEF);
    chk("bp_f1_last",  32'(last_out),   32'd1);
    tick();
    chk("bp_done",     32'(valid_out),  32'd0);

    // count_sel flips mid-word; only the next word sees it.
    count_sel = 1'b0; parallel_in_0 = 32'hBEEF_1234; valid_in = 1'b1;
    tick(); valid_in = 1'b0; count_sel = 1'b1; #1;
    chk("cs_f0",      32'(serial_out), 32'h1234);
    chk("cs_f0_last", 32'(last_out),   32'd0);
    tick();
    parallel_in_1 = 16'h5A5A; valid_in = 1'b1; #1;
    chk("cs_f1",      32'(serial_out), 32'hBEEF);
    chk("cs_f1_last", 32'(last_out),   32'd1);
    tick(); valid_in = 1'b0; #1;
    chk("cs_n0",      32'(serial_out), 32'h5A5A);
    chk("cs_n0_last", 32'(last_out),   32'd1);
    tick();
    chk("cs_done",    32'(valid_out),  32'd0);

    // Reset mid-word drops the second flit.
    count_sel = 1'b0; parallel_in_0 = 32'hCAFE_0001; valid_in = 1'b1;
    tick(); valid_in = 1'b0; #1;
    chk("mr_f0", 32'(serial_out), 32'h0001);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("mr_valid", 32'(valid_out), 32'd0);
    chk("mr_ready", 32'(ready_out), 32'd1);
    chk("mr_last",  32'(last_out),  32'd0);
    tick();
    chk("mr_gone",  32'(valid_out), 32'd0);

    // Word offered during reset is ignored.
    rst = 1'b1; valid_in = 1'b1;
    tick(); rst = 1'b0; valid_in = 1'b0; #1;
    chk("ra_valid", 32'(valid_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
